serial_in_capture: RTL and testbench



---
 rtl/serial_in_capture_pkg.sv | 18 +
 rtl/serial_in_capture_line_sync.sv | 34 +++
 rtl/serial_in_capture.sv | 159 +++++++++++++++
 tb/tb_serial_in_capture.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_in_capture_pkg.sv
// Shared definitions for the serial link receiver; default field widths match the serial out buffer.
package serial_in_capture_pkg;

    localparam int SIC_ADDR_W = 7;
    localparam int SIC_DATA_W = 8;
    localparam int FRAME_W    = SIC_ADDR_W + SIC_DATA_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SHIFT     = 2'd1,
        WAIT_STOP = 2'd2
    } sic_state_e;

    function automatic int frame_width(input int aw, input int dw);
        return aw + dw;
    endfunction

endpackage

// File: rtl/serial_in_capture_line_sync.sv
// N-flop synchronizer plus one history flop; reports the previous synced level and its edges.
// Reset value is the idle-high line level so reset never fabricates an edge.
module line_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_in,
    input  logic reset,
    input  logic line_i,
    output logic prev_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;
    logic              cur;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sync_q <= {STAGES{RST_VAL}};
            hist_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], line_i};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign cur    = sync_q[STAGES-1];
    assign prev_o = hist_q;
    assign rise_o = cur & ~hist_q;
    assign fall_o = ~cur & hist_q;

endmodule

// File: rtl/serial_in_capture.sv
// Two-wire serial receiver: START, FRAME_W bits MSB-first on InC rises, STOP -> {A_out, D_out} + Valid.
// Valid lands SYNC_STAGES+2 cycles after the STOP pin edge; framing faults pulse FrameErr instead.
module serial_in_capture
    import serial_in_capture_pkg::*;
#(
    parameter int ADDR_W      = SIC_ADDR_W,
    parameter int DATA_W      = SIC_DATA_W,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              InD,
    input  logic              InC,
    output logic [ADDR_W-1:0] A_out,
    output logic [DATA_W-1:0] D_out,
    output logic              Valid,
    output logic              FrameErr,
    output logic              Busy
);

    localparam int                FW       = frame_width(ADDR_W, DATA_W);
    localparam int                CNT_W    = $clog2(FW + 1);
    localparam int                TO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(FW - 1);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

    logic d_prev, d_rise, d_fall;
    logic c_prev, c_rise, c_fall;

    line_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_d (
        .clk_in (clk_in),
        .reset  (reset),
        .line_i (InD),
        .prev_o (d_prev),
        .rise_o (d_rise),
        .fall_o (d_fall)
    );

    line_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_c (
        .clk_in (clk_in),
        .reset  (reset),
        .line_i (InC),
        .prev_o (c_prev),
        .rise_o (c_rise),
        .fall_o (c_fall)
    );

    // START/STOP need InC high and unchanged; any InC movement makes the cycle a clock event only.
    // A bit takes the data level from before the InC rise, so InD may move in that same cycle.
    logic c_hold;
    logic start_d, stop_d, bit_d, bval_d;
    logic start_q, stop_q, bit_q, bval_q;

    assign c_hold  = c_prev & ~c_fall;
    assign start_d = d_fall & c_hold;
    assign stop_d  = d_rise & c_hold;
    assign bit_d   = c_rise;
    assign bval_d  = d_prev;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            bit_q   <= 1'b0;
            bval_q  <= 1'b0;
        end else begin
            start_q <= start_d;
            stop_q  <= stop_d;
            bit_q   <= bit_d;
            bval_q  <= bval_d;
        end
    end

    sic_state_e        state_q;
    logic [FW-1:0]     shift_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [TO_W-1:0]   to_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q, err_q, busy_q;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            to_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_q) begin
                        state_q <= SHIFT;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        shift_q <= '0;
                        to_q    <= '0;
                    end
                end
                SHIFT, WAIT_STOP: begin
                    if (start_q) begin
                        err_q   <= 1'b1;
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                        shift_q <= '0;
                        to_q    <= '0;
                    end else if (stop_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        if (state_q == WAIT_STOP) begin
                            valid_q <= 1'b1;
                            addr_q  <= shift_q[FW-1 -: ADDR_W];
                            data_q  <= shift_q[DATA_W-1:0];
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else if (bit_q) begin
                        if (state_q == WAIT_STOP) begin
                            err_q   <= 1'b1;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            shift_q <= {shift_q[FW-2:0], bval_q};
                            cnt_q   <= cnt_q + 1'b1;
                            to_q    <= '0;
                            if (cnt_q == LAST_BIT) begin
                                state_q <= WAIT_STOP;
                            end
                        end
                    end else if (to_q == TO_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        to_q <= to_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign A_out    = addr_q;
    assign D_out    = data_q;
    assign Valid    = valid_q;
    assign FrameErr = err_q;
    assign Busy     = busy_q;

endmodule

// File: tb/tb_serial_in_capture.sv
// Drives the two-wire line with random frames and compares pulses/outputs against an outcome queue.
module tb_serial_in_capture;

    localparam int SYNC = 2;
    localparam int TO   = 255;

    logic       clk_in = 1'b0;
    logic       reset  = 1'b1;
    logic       InD    = 1'b1;
    logic       InC    = 1'b1;
    logic [6:0] A_out;
    logic [7:0] D_out;
    logic       Valid, FrameErr, Busy;

    serial_in_capture #(
        .ADDR_W(7), .DATA_W(8), .SYNC_STAGES(SYNC), .TIMEOUT_CYC(TO)
    ) dut (
        .clk_in(clk_in), .reset(reset), .InD(InD), .InC(InC),
        .A_out(A_out), .D_out(D_out), .Valid(Valid), .FrameErr(FrameErr), .Busy(Busy)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int h     = 5;

    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        bit       is_err;
        logic [6:0] a;
        logic [7:0] d;
        int       stop_cyc;
    } exp_t;

    exp_t       expq[$];
    exp_t       e_mon;
    logic [6:0] mdl_a = '0;
    logic [7:0] mdl_d = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Outcome monitor: each pulse consumes the next expected frame outcome.
    initial begin
        forever begin
            @(negedge clk_in);
            if (!reset) begin
                if (Valid || FrameErr) begin
                    check("excl", {31'd0, Valid & FrameErr}, 0);
                    if (expq.size() == 0) begin
                        check("unexpected_pulse", 1, 0);
                    end else begin
                        e_mon = expq.pop_front();
                        check("pulse_kind_err", {31'd0, FrameErr}, {31'd0, e_mon.is_err});
                        if (Valid && !e_mon.is_err) begin
                            mdl_a = e_mon.a;
                            mdl_d = e_mon.d;
                            check("valid_latency", cyc - e_mon.stop_cyc, SYNC + 2);
                        end
                    end
                end
                check("A_out", {25'd0, A_out}, {25'd0, mdl_a});
                check("D_out", {24'd0, D_out}, {24'd0, mdl_d});
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic push_exp(input bit is_err, input logic [6:0] a, input logic [7:0] d);
        exp_t e;
        e.is_err   = is_err;
        e.a        = a;
        e.d        = d;
        e.stop_cyc = cyc;
        expq.push_back(e);
    endtask

    task automatic tx_start();
        InD = 1'b0;
        wait_cyc(h);
    endtask

    // One bit cell; 'post' is the InD level driven in the same cycle as the InC rise.
    task automatic tx_bit(input logic b, input logic post);
        InC = 1'b0;
        wait_cyc(h);
        InD = b;
        wait_cyc(h);
        InC = 1'b1;
        InD = post;
        wait_cyc(h);
    endtask

    task automatic tx_bits(input logic [15:0] v, input int n, input logic post_last);
        for (int i = n - 1; i >= 0; i--) tx_bit(v[i], (i == 0) ? post_last : v[i]);
    endtask

    task automatic settle();
        wait_cyc(12);
        check("pending_outcomes", expq.size(), 0);
        check("busy_idle", {31'd0, Busy}, 0);
    endtask

    task automatic good_frame(input logic [6:0] a, input logic [7:0] d, input int gap);
        tx_start();
        tx_bits({1'b0, a, d}, 15, 1'b0);
        check("busy_frame", {31'd0, Busy}, 1);
        InD = 1'b1;
        push_exp(1'b0, a, d);
        wait_cyc(gap);
    endtask

    task automatic short_frame(input int n);
        tx_start();
        push_exp(1'b1, '0, '0);
        tx_bits(16'($urandom), n, 1'b0);
        InD = 1'b1;
        wait_cyc(h);
    endtask

    task automatic long_frame();
        tx_start();
        push_exp(1'b1, '0, '0);
        tx_bits(16'($urandom), 16, 1'b0);
        InD = 1'b1;
        wait_cyc(h);
    endtask

    task automatic restart_frame(input int k, input logic [6:0] a, input logic [7:0] d);
        tx_start();
        push_exp(1'b1, '0, '0);
        tx_bits(16'($urandom), k, 1'b1);
        InD = 1'b0;
        wait_cyc(h);
        check("busy_restart", {31'd0, Busy}, 1);
        tx_bits({1'b0, a, d}, 15, 1'b0);
        InD = 1'b1;
        push_exp(1'b0, a, d);
        wait_cyc(h);
    endtask

    task automatic timeout_frame(input int k);
        logic [15:0] v;
        v = 16'($urandom);
        tx_start();
        push_exp(1'b1, '0, '0);
        tx_bits(v, k, v[0]);
        InC = 1'b0;
        wait_cyc(TO + 5);
        check("busy_after_timeout", {31'd0, Busy}, 0);
        InD = 1'b0;
        wait_cyc(h);
        InC = 1'b1;
        wait_cyc(h);
        InD = 1'b1;
        wait_cyc(h);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] ra;
        logic [7:0] rd;
        int         kind;

        wait_cyc(3);
        check("rst_A", {25'd0, A_out}, 0);
        check("rst_D", {24'd0, D_out}, 0);
        check("rst_pulses", {30'd0, Valid, FrameErr}, 0);
        check("rst_busy", {31'd0, Busy}, 0);
        reset = 1'b0;
        wait_cyc(4);

        h = 5;
        good_frame(7'h7F, 8'hFF, h);
        settle();

        h = 3;
        good_frame(7'h2A, 8'hC3, 1);
        good_frame(7'h01, 8'h00, h);
        settle();

        short_frame(9);
        settle();

        long_frame();
        good_frame(7'h55, 8'hAA, h);
        settle();

        timeout_frame(6);
        settle();

        restart_frame(5, 7'h10, 8'h80);
        settle();

        tx_start();
        tx_bits(16'h1234, 7, 1'b0);
        reset = 1'b1;
        #1;
        check("midrst_A", {25'd0, A_out}, 0);
        check("midrst_D", {24'd0, D_out}, 0);
        check("midrst_pulses", {30'd0, Valid, FrameErr}, 0);
        check("midrst_busy", {31'd0, Busy}, 0);
        InD = 1'b1;
        InC = 1'b1;
        expq.delete();
        mdl_a = '0;
        mdl_d = '0;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(4);
        good_frame(7'h3C, 8'h5A, h);
        settle();

        for (int it = 0; it < 30; it++) begin
            h    = $urandom_range(2, 6);
            ra   = 7'($urandom);
            rd   = 8'($urandom);
            kind = $urandom_range(0, 6);
            case (kind)
                0, 1: begin
                    good_frame(ra, rd, h);
                    settle();
                end
                2: good_frame(ra, rd, 1);
                3: begin
                    short_frame($urandom_range(1, 14));
                    settle();
                end
                4: begin
                    long_frame();
                    settle();
                end
                5: begin
                    restart_frame($urandom_range(1, 14), ra, rd);
                    settle();
                end
                default: begin
                    timeout_frame($urandom_range(0, 15));
                    settle();
                end
            endcase
        end
        wait_cyc(3 * h + 4);
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
